// File: rtl/edge_ahb_pkg.sv
// Shared types and encodings for the edge-detector AHB access scheduler.
package edge_ahb_pkg;

    localparam int unsigned HTRANS_W = 2;
    localparam int unsigned STATUS_W = 2;
    localparam int unsigned STREAK_W = 8;

    localparam logic [HTRANS_W-1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [HTRANS_W-1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [STATUS_W-1:0] STATUS_PAUSE = 2'b00;
    localparam logic [STATUS_W-1:0] STATUS_RUN   = 2'b10;
    localparam logic [STATUS_W-1:0] STATUS_ABORT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARB,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_ADDR,
        S_WR_DATA,
        S_DONE,
        S_ERROR
    } sched_state_t;

    // Pause and the reserved code 01 both have status[1] clear.
    function automatic logic status_is_pause(input logic [STATUS_W-1:0] st);
        return !st[1];
    endfunction

endpackage

// File: rtl/sched_wait_timer.sv
// HREADY-low watchdog: counts consecutive stalled cycles of a transfer and
// flags expiry on the cycle that would be the TIMEOUT_CYCLES-th stalled one.
module sched_wait_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic HCLK,
    input  logic HRESET,
    input  logic count_en,
    output logic expired_c
);

    localparam int unsigned CNT_W = 16;

    logic [CNT_W-1:0] wait_cnt_q;

    // Count while stalled, restart whenever the stall ends; saturate at all-ones.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            wait_cnt_q <= '0;
        end else if (!count_en) begin
            wait_cnt_q <= '0;
        end else if (wait_cnt_q != '1) begin
            wait_cnt_q <= wait_cnt_q + CNT_W'(1);
        end
    end

    assign expired_c = count_en && (wait_cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/ahb_access_scheduler.sv
// Read/write arbiter and single-transfer AHB sequencer for the edge detector.
// Optional HREADY watchdog enabled by defining WAIT_TIMEOUT_EN.
module ahb_access_scheduler
    import edge_ahb_pkg::*;
#(
    parameter int unsigned RD_BURST_MAX = 4
`ifdef WAIT_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT_CYCLES = 256
`endif
) (
    input  logic                HCLK,
    input  logic                HRESET,
    input  logic [STATUS_W-1:0] status,
    input  logic                rd_req,
    input  logic                wr_req,
    input  logic                end_of_image,
    input  logic                wr_end_of_image,
    input  logic                HREADY,
    input  logic                HRESP,
    output logic [HTRANS_W-1:0] HTRANS,
    output logic                HWRITE,
    output logic                sel_w,
    output logic                addr_update_enable_r,
    output logic                addr_update_enable_w,
    output logic                rd_data_valid,
    output logic                wr_data_ack,
    output logic                busy,
    output logic                done,
    output logic                error
);

    sched_state_t          state_q, state_d;
    logic [STREAK_W-1:0]   rd_streak_q, rd_streak_d;
    logic [HTRANS_W-1:0]   htrans_d;
    logic                  hwrite_d, sel_w_d, busy_d, done_d, error_d;
    logic                  rd_done_c, wr_done_c;
    logic                  rd_elig_c, wr_elig_c;
    logic                  timeout_c;

    assign rd_elig_c = rd_req && !end_of_image;
    assign wr_elig_c = wr_req && !wr_end_of_image;

`ifdef WAIT_TIMEOUT_EN
    logic wait_en_c;

    // Stall watchdog runs only while a transfer is held off by HREADY.
    assign wait_en_c = !HREADY && (state_q inside {S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA});

    sched_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .count_en  (wait_en_c),
        .expired_c (timeout_c)
    );
`else
    assign timeout_c = 1'b0;
`endif

    // State, read-streak and registered bus/status outputs.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            rd_streak_q <= '0;
            HTRANS      <= HTRANS_IDLE;
            HWRITE      <= 1'b0;
            sel_w       <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_streak_q <= rd_streak_d;
            HTRANS      <= htrans_d;
            HWRITE      <= hwrite_d;
            sel_w       <= sel_w_d;
            busy        <= busy_d;
            done        <= done_d;
            error       <= error_d;
        end
    end

    // Next state, completion strobes, streak update and next-cycle output decode.
    always_comb begin
        state_d     = state_q;
        rd_done_c   = 1'b0;
        wr_done_c   = 1'b0;
        rd_streak_d = rd_streak_q;
        htrans_d    = HTRANS_IDLE;
        hwrite_d    = 1'b0;
        sel_w_d     = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        error_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (status == STATUS_RUN) state_d = S_ARB;
            end
            S_ARB: begin
                if (status != STATUS_RUN) begin
                    state_d = S_IDLE;
                end else if (end_of_image && wr_end_of_image) begin
                    state_d = S_DONE;
                end else if (rd_elig_c && wr_elig_c) begin
                    state_d = (rd_streak_q >= STREAK_W'(RD_BURST_MAX)) ? S_WR_ADDR : S_RD_ADDR;
                end else if (rd_elig_c) begin
                    state_d = S_RD_ADDR;
                end else if (wr_elig_c) begin
                    state_d = S_WR_ADDR;
                end
            end
            S_RD_ADDR: begin
                if (timeout_c)   state_d = S_ERROR;
                else if (HREADY) state_d = S_RD_DATA;
            end
            S_WR_ADDR: begin
                if (timeout_c)   state_d = S_ERROR;
                else if (HREADY) state_d = S_WR_DATA;
            end
            S_RD_DATA: begin
                if (HREADY) begin
                    if (HRESP) begin
                        state_d = S_ERROR;
                    end else begin
                        rd_done_c = 1'b1;
                        state_d   = S_ARB;
                    end
                end else if (timeout_c) begin
                    state_d = S_ERROR;
                end
            end
            S_WR_DATA: begin
                if (HREADY) begin
                    if (HRESP) begin
                        state_d = S_ERROR;
                    end else begin
                        wr_done_c = 1'b1;
                        state_d   = S_ARB;
                    end
                end else if (timeout_c) begin
                    state_d = S_ERROR;
                end
            end
            S_DONE: begin
                if (status_is_pause(status)) state_d = S_IDLE;
            end
            S_ERROR: begin
                if (status == STATUS_ABORT) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (wr_done_c) begin
            rd_streak_d = '0;
        end else if (rd_done_c && (rd_streak_q != '1)) begin
            rd_streak_d = rd_streak_q + STREAK_W'(1);
        end

        case (state_d)
            S_RD_ADDR: begin
                htrans_d = HTRANS_NONSEQ;
                busy_d   = 1'b1;
            end
            S_WR_ADDR: begin
                htrans_d = HTRANS_NONSEQ;
                hwrite_d = 1'b1;
                sel_w_d  = 1'b1;
                busy_d   = 1'b1;
            end
            S_RD_DATA, S_WR_DATA: busy_d  = 1'b1;
            S_DONE:               done_d  = 1'b1;
            S_ERROR:              error_d = 1'b1;
            default: ;
        endcase
    end

    // Completion strobes must coincide with the HREADY data beat, so they stay combinational.
    assign rd_data_valid        = rd_done_c;
    assign addr_update_enable_r = rd_done_c;
    assign wr_data_ack          = wr_done_c;
    assign addr_update_enable_w = wr_done_c;

endmodule

// File: tb/tb_ahb_access_scheduler.sv
// Scoreboard bench for ahb_access_scheduler: expected grant kinds are queued
// as requests are driven and checked against each completion pulse.
module tb_ahb_access_scheduler;

    localparam int RD_BURST = 4;

    logic       tb_HCLK = 1'b0;
    logic       HRESET;
    logic [1:0] status;
    logic       rd_req, wr_req, end_of_image, wr_end_of_image, HREADY, HRESP;
    logic [1:0] HTRANS;
    logic       HWRITE, sel_w, addr_update_enable_r, addr_update_enable_w;
    logic       rd_data_valid, wr_data_ack, busy, done, error;

    int  n_vec  = 0;
    int  n_miss = 0;
    int  pulse_cnt = 0;
    int  model_streak = 0;
    bit  exp_q[$];
    bit  prev_pulse = 1'b0;
    bit  exp_kind;
    logic pr, pw;

    always #5 tb_HCLK = ~tb_HCLK;

    ahb_access_scheduler #(
        .RD_BURST_MAX (RD_BURST)
`ifdef WAIT_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES (8)
`endif
    ) dut (
        .HCLK                 (tb_HCLK),
        .HRESET               (HRESET),
        .status               (status),
        .rd_req               (rd_req),
        .wr_req               (wr_req),
        .end_of_image         (end_of_image),
        .wr_end_of_image      (wr_end_of_image),
        .HREADY               (HREADY),
        .HRESP                (HRESP),
        .HTRANS               (HTRANS),
        .HWRITE               (HWRITE),
        .sel_w                (sel_w),
        .addr_update_enable_r (addr_update_enable_r),
        .addr_update_enable_w (addr_update_enable_w),
        .rd_data_valid        (rd_data_valid),
        .wr_data_ack          (wr_data_ack),
        .busy                 (busy),
        .done                 (done),
        .error                (error)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference arbiter: queues the grant kind (1 = write) for n transfers.
    task automatic push_grants(input bit rd_el, input bit wr_el, input int n);
        for (int i = 0; i < n; i++) begin
            bit w;
            if (rd_el && wr_el) w = (model_streak >= RD_BURST);
            else                w = wr_el;
            exp_q.push_back(w);
            if (w)                       model_streak = 0;
            else if (model_streak < 255) model_streak++;
        end
    endtask

    task automatic await_pulses(input int target, input string tag);
        int budget = 300;
        while (pulse_cnt < target && budget > 0) begin
            @(negedge tb_HCLK); #1;
            budget--;
        end
        if (pulse_cnt < target) check_val(tag, 32'(pulse_cnt), 32'(target));
    endtask

    task automatic wait_nonseq(input string tag);
        int budget = 50;
        bit seen = 1'b0;
        while (!seen && budget > 0) begin
            @(negedge tb_HCLK);
            seen = (HTRANS == 2'b10);
            budget--;
        end
        if (!seen) check_val(tag, 32'(HTRANS), 32'h2);
    endtask

    // Call at posedge+1 with the FSM idle in ARB/IDLE; returns at posedge+1 with requests dropped.
    task automatic drive_and_collect(input bit rd, input bit wr, input int n, input string tag);
        int target = pulse_cnt + n;
        push_grants(rd && !end_of_image, wr && !wr_end_of_image, n);
        rd_req = rd;
        wr_req = wr;
        await_pulses(target, {tag, "_timeout"});
        @(posedge tb_HCLK); #1;
        rd_req = 1'b0;
        wr_req = 1'b0;
        check_val({tag, "_drain"}, 32'(exp_q.size()), 32'h0);
    endtask

    // Scoreboard monitor: pop and compare on every completion pulse.
    always @(negedge tb_HCLK) begin
        if (HRESET) begin
            prev_pulse = 1'b0;
        end else begin
            pr = addr_update_enable_r;
            pw = addr_update_enable_w;
            if (HTRANS == 2'b10 && exp_q.size() != 0) begin
                check_val("addr_hwrite", 32'(HWRITE), 32'(exp_q[0]));
                check_val("addr_sel_w", 32'(sel_w), 32'(exp_q[0]));
            end
            if (pr || pw) begin
                pulse_cnt++;
                check_val("back_to_back", 32'(prev_pulse), 32'h0);
                check_val("one_hot", 32'(pr & pw), 32'h0);
                check_val("rd_valid_pair", 32'(rd_data_valid), 32'(pr));
                check_val("wr_ack_pair", 32'(wr_data_ack), 32'(pw));
                if (exp_q.size() == 0) begin
                    check_val("unexpected_pulse", 32'({pr, pw}), 32'h0);
                end else begin
                    exp_kind = exp_q.pop_front();
                    check_val("grant_kind", 32'(pw), 32'(exp_kind));
                end
            end
            prev_pulse = pr | pw;
        end
    end

    initial begin
        int base;
        HRESET = 1'b1; status = 2'b00; rd_req = 1'b0; wr_req = 1'b0;
        end_of_image = 1'b0; wr_end_of_image = 1'b0; HREADY = 1'b1; HRESP = 1'b0;

        // Reset values
        repeat (2) @(posedge tb_HCLK);
        @(negedge tb_HCLK);
        check_val("rst_htrans", 32'(HTRANS), 32'h0);
        check_val("rst_flags", 32'({HWRITE, sel_w, busy, done, error}), 32'h0);
        check_val("rst_pulses", 32'({addr_update_enable_r, addr_update_enable_w, rd_data_valid, wr_data_ack}), 32'h0);

        // 1: read-only stream, one transfer per 3 cycles
        @(posedge tb_HCLK); #1;
        HRESET = 1'b0; status = 2'b10; rd_req = 1'b1;
        push_grants(1'b1, 1'b0, 3);
        @(posedge tb_HCLK);
        for (int k = 0; k < 9; k++) begin
            @(negedge tb_HCLK);
            check_val("t1_htrans", 32'(HTRANS), (k % 3 == 1) ? 32'h2 : 32'h0);
            check_val("t1_pulse_r", 32'(addr_update_enable_r), (k % 3 == 2) ? 32'h1 : 32'h0);
        end
        @(posedge tb_HCLK); #1;
        rd_req = 1'b0;
        check_val("t1_drain", 32'(exp_q.size()), 32'h0);

        // 2: read burst limit against a pending write
        drive_and_collect(1'b0, 1'b1, 1, "t2_pre");
        drive_and_collect(1'b1, 1'b1, 10, "t2_mix");

        // 3: pause during a stalled read data phase
        rd_req = 1'b1;
        push_grants(1'b1, 1'b0, 1);
        base = pulse_cnt;
        wait_nonseq("t3_nonseq");
        @(posedge tb_HCLK); #1;
        HREADY = 1'b0; status = 2'b00; rd_req = 1'b0;
        repeat (2) begin
            @(negedge tb_HCLK);
            check_val("t3_busy_stall", 32'(busy), 32'h1);
            check_val("t3_no_pulse", 32'(addr_update_enable_r), 32'h0);
        end
        @(posedge tb_HCLK); #1;
        HREADY = 1'b1;
        repeat (4) @(negedge tb_HCLK);
        check_val("t3_one_pulse", 32'(pulse_cnt - base), 32'h1);
        check_val("t3_idle_busy", 32'(busy), 32'h0);
        @(posedge tb_HCLK); #1;
        status = 2'b10;
        drive_and_collect(1'b1, 1'b0, 1, "t3_resume");

        // 4: error response on a write data phase
        wr_req = 1'b1;
        base = pulse_cnt;
        wait_nonseq("t4_nonseq");
        @(posedge tb_HCLK); #1;
        HRESP = 1'b1; wr_req = 1'b0;
        @(negedge tb_HCLK);
        check_val("t4_no_pulse_w", 32'({addr_update_enable_w, wr_data_ack}), 32'h0);
        @(posedge tb_HCLK); #1;
        HRESP = 1'b0;
        @(negedge tb_HCLK);
        check_val("t4_error", 32'(error), 32'h1);
        repeat (3) @(negedge tb_HCLK);
        check_val("t4_error_sticky", 32'(error), 32'h1);
        check_val("t4_err_htrans", 32'(HTRANS), 32'h0);
        @(posedge tb_HCLK); #1;
        status = 2'b11;
        @(posedge tb_HCLK);
        @(negedge tb_HCLK);
        check_val("t4_error_clr", 32'(error), 32'h0);
        check_val("t4_pulses", 32'(pulse_cnt - base), 32'h0);

        // 5: reads exhausted, writes only, then done
        @(posedge tb_HCLK); #1;
        status = 2'b10; end_of_image = 1'b1;
        drive_and_collect(1'b1, 1'b1, 3, "t5_writes");
        wr_end_of_image = 1'b1;
        @(posedge tb_HCLK);
        @(negedge tb_HCLK);
        check_val("t5_done", 32'(done), 32'h1);
        check_val("t5_done_htrans", 32'(HTRANS), 32'h0);
        @(posedge tb_HCLK); #1;
        status = 2'b00;
        @(posedge tb_HCLK);
        @(negedge tb_HCLK);
        check_val("t5_done_clr", 32'(done), 32'h0);
        @(posedge tb_HCLK); #1;
        end_of_image = 1'b0; wr_end_of_image = 1'b0;

        // 6: HREADY held low in the read address phase
        HREADY = 1'b0; status = 2'b10; rd_req = 1'b1;
        wait_nonseq("t6_nonseq");
`ifdef WAIT_TIMEOUT_EN
        repeat (7) begin
            @(negedge tb_HCLK);
            check_val("t6_pre_timeout", 32'(error), 32'h0);
        end
        @(negedge tb_HCLK);
        check_val("t6_timeout", 32'(error), 32'h1);
        @(posedge tb_HCLK); #1;
        status = 2'b11; rd_req = 1'b0; HREADY = 1'b1;
        @(posedge tb_HCLK);
        @(negedge tb_HCLK);
        check_val("t6_abort_clr", 32'(error), 32'h0);
`else
        repeat (20) @(negedge tb_HCLK);
        check_val("t6_still_wait", 32'(HTRANS), 32'h2);
        check_val("t6_no_error", 32'(error), 32'h0);
        @(posedge tb_HCLK); #1;
        base = pulse_cnt + 1;
        push_grants(1'b1, 1'b0, 1);
        status = 2'b00; rd_req = 1'b0; HREADY = 1'b1;
        await_pulses(base, "t6_release_timeout");
        check_val("t6_drain", 32'(exp_q.size()), 32'h0);
`endif

        // 7: reset during a stalled transfer gives no pulse
        @(posedge tb_HCLK); #1;
        status = 2'b10; rd_req = 1'b1; HREADY = 1'b0;
        wait_nonseq("t7_nonseq");
        @(posedge tb_HCLK); #1;
        base = pulse_cnt;
        HRESET = 1'b1; HREADY = 1'b1;
        model_streak = 0;
        @(negedge tb_HCLK);
        check_val("t7_rst_htrans", 32'(HTRANS), 32'h0);
        check_val("t7_rst_busy", 32'(busy), 32'h0);
        check_val("t7_rst_pulse", 32'(addr_update_enable_r), 32'h0);
        @(posedge tb_HCLK); #1;
        HRESET = 1'b0; status = 2'b00; rd_req = 1'b0;
        repeat (3) @(negedge tb_HCLK);
        check_val("t7_no_pulse", 32'(pulse_cnt - base), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
